sqwave_gen: RTL and testbench

Synthesisable, parametrised multi-channel square-wave generator. It produces `NCH` independent registered waveforms from one system clock. Each channel has a programmable period, high time and phase offset, supports glitch-free reconfiguration and stop, and can be phase-aligned with the other channels. It replaces fixed simulation-only clock toggling as the source of derived strobes and sample clocks such as `sclk`-style serial clocks and ~9 MHz test tones.

---
 rtl/sqwave_pkg.sv | 28 ++
 rtl/sqwave_chan.sv | 96 +++++++++
 rtl/sqwave_gen.sv | 42 ++++
 tb/tb_sqwave_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sqwave_pkg.sv
// rtl/sqwave_pkg.sv - shared types, constants and effective-value helpers for sqwave_gen
package sqwave_pkg;

  localparam int SQW_CNT_W      = 16;
  localparam int SQW_MIN_PERIOD = 2;

  typedef struct packed {
    logic [SQW_CNT_W-1:0] period;
    logic [SQW_CNT_W-1:0] high;
    logic [SQW_CNT_W-1:0] phase;
  } sqwave_cfg_t;

  typedef enum logic [1:0] {
    SQW_IDLE  = 2'd0,
    SQW_RUN   = 2'd1,
    SQW_DRAIN = 2'd2
  } sqwave_st_e;

  function automatic logic [SQW_CNT_W-1:0] sqw_eff_period(input logic [SQW_CNT_W-1:0] p);
    return (p < SQW_CNT_W'(SQW_MIN_PERIOD)) ? SQW_CNT_W'(SQW_MIN_PERIOD) : p;
  endfunction

  // Out-of-range phases start at 0 so the counter can never pass the wrap point.
  function automatic logic [SQW_CNT_W-1:0] sqw_eff_phase(input sqwave_cfg_t c);
    return (c.phase < sqw_eff_period(c.period)) ? c.phase : '0;
  endfunction

endpackage

// File: rtl/sqwave_chan.sv
// rtl/sqwave_chan.sv - one square-wave channel: shadow/active config, FSM, counter, output flops
module sqwave_chan
  import sqwave_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sync_start,
  input  logic        wr,
  input  sqwave_cfg_t wcfg,
  output logic        wave_o,
  output logic        wrap_o,
  output logic        busy_o
);

  localparam logic [SQW_CNT_W-1:0] ONE = SQW_CNT_W'(1);

  sqwave_st_e           st_q, st_d;
  sqwave_cfg_t          shd_q, act_q, act_d;
  logic [SQW_CNT_W-1:0] cnt_q, cnt_d;
  logic                 wave_d, wrap_d;
  logic                 last, reload, running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= SQW_IDLE;
      shd_q  <= '0;
      act_q  <= '0;
      cnt_q  <= '0;
      wave_o <= 1'b0;
      wrap_o <= 1'b0;
    end else begin
      st_q   <= st_d;
      act_q  <= act_d;
      cnt_q  <= cnt_d;
      wave_o <= wave_d;
      wrap_o <= wrap_d;
      if (wr) shd_q <= wcfg;
    end
  end

  assign busy_o = (st_q != SQW_IDLE);

  always_comb begin
    st_d    = st_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    last    = (cnt_q == sqw_eff_period(act_q.period) - ONE);
    reload  = 1'b0;
    unique case (st_q)
      SQW_IDLE: begin
        // Start straight from the shadow so a write the cycle before en takes effect.
        act_d = shd_q;
        cnt_d = '0;
        if (en) begin
          st_d  = SQW_RUN;
          cnt_d = sqw_eff_phase(shd_q);
        end
      end
      SQW_RUN: begin
        if (sync_start) begin
          reload = 1'b1;
          cnt_d  = sqw_eff_phase(act_q);
          if (!en) st_d = SQW_DRAIN;
        end else if (last) begin
          cnt_d = '0;
          act_d = shd_q;
          if (!en) st_d = SQW_IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
          if (!en) st_d = SQW_DRAIN;
        end
      end
      SQW_DRAIN: begin
        if (last) begin
          cnt_d = '0;
          act_d = shd_q;
          st_d  = en ? SQW_RUN : SQW_IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
          if (en) st_d = SQW_RUN;
        end
      end
      default: begin
        st_d  = SQW_IDLE;
        cnt_d = '0;
      end
    endcase
    if (st_d == SQW_IDLE) cnt_d = '0;
    running = (st_d != SQW_IDLE);
    // Outputs are computed from next-state values so the flops line up with the counter.
    wave_d  = running && (cnt_d < act_d.high);
    wrap_d  = running && !reload && (cnt_d == sqw_eff_period(act_d.period) - ONE);
  end

endmodule

// File: rtl/sqwave_gen.sv
// rtl/sqwave_gen.sv - multi-channel square-wave generator: write decode and channel array
module sqwave_gen
  import sqwave_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = SQW_CNT_W,  // must equal sqwave_pkg::SQW_CNT_W
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             sync_start,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic [NCH-1:0]   wave_o,
  output logic [NCH-1:0]   wrap_o,
  output logic [NCH-1:0]   busy_o
);

  sqwave_cfg_t wcfg;

  assign wcfg = '{period: cfg_period, high: cfg_high, phase: cfg_phase};

  // Indices at or above NCH match no channel, so such writes are dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    sqwave_chan u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en[i]),
      .sync_start (sync_start),
      .wr         (cfg_wr && (cfg_ch == CH_W'(i))),
      .wcfg       (wcfg),
      .wave_o     (wave_o[i]),
      .wrap_o     (wrap_o[i]),
      .busy_o     (busy_o[i])
    );
  end

endmodule

// File: tb/tb_sqwave_gen.sv
// tb/tb_sqwave_gen.sv - directed self-checking bench for sqwave_gen
module tb_sqwave_gen;

  localparam int NCH = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  en;
  logic        sync_start;
  logic        cfg_wr;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_period, cfg_high, cfg_phase;
  logic [2:0]  wave_o, wrap_o, busy_o;

  int checks = 0;
  int errors = 0;

  sqwave_gen #(.NCH(NCH), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sync_start (sync_start),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_phase  (cfg_phase),
    .wave_o     (wave_o),
    .wrap_o     (wrap_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Running channel at count c: expect {busy,wrap,wave} = {1, c==p-1, c<h}.
  task automatic chk_ch(input string tag, input int ch, input int c, input int p, input int h);
    chk($sformatf("%s ch%0d cnt%0d", tag, ch, c),
        {29'd0, busy_o[ch], wrap_o[ch], wave_o[ch]},
        {29'd0, 1'b1, c == p - 1, c < h});
  endtask

  task automatic run_seq(input string tag, input int ch, input int n, input int p, input int h,
                         input int c0);
    int c = c0;
    for (int k = 0; k < n; k++) begin
      chk_ch(tag, ch, c, p, h);
      c = (c + 1) % p;
      @(negedge clk);
    end
  endtask

  task automatic set_cfg(input int ch, input int p, input int h, input int ph);
    cfg_wr     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = 16'(p);
    cfg_high   = 16'(h);
    cfg_phase  = 16'(ph);
  endtask

  initial begin
    rst_n = 1'b0; en = '0; sync_start = 1'b0; cfg_wr = 1'b0;
    cfg_ch = '0; cfg_period = '0; cfg_high = '0; cfg_phase = '0;
    repeat (2) @(negedge clk);
    chk("rst_wave", 32'(wave_o), 32'd0);
    chk("rst_wrap", 32'(wrap_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // write to nonexistent channel 3 must not reach ch2, which keeps P=2 H=0
    set_cfg(3, 4, 4, 0);
    @(negedge clk);
    cfg_wr = 1'b0;
    en[2] = 1'b1;
    @(negedge clk);
    run_seq("ign", 2, 4, 2, 0, 0);
    en[2] = 1'b0;
    repeat (2) @(negedge clk);
    chk("ign_idle", {30'd0, busy_o[2], wave_o[2]}, 32'd0);

    // basic 10/5 waveform
    set_cfg(0, 10, 5, 0);
    @(negedge clk);
    cfg_wr = 1'b0;
    en[0] = 1'b1;
    @(negedge clk);
    run_seq("t1", 0, 20, 10, 5, 0);

    // mid-period write, then write on the wrap cycle
    run_seq("t3a", 0, 3, 10, 5, 0);
    set_cfg(0, 6, 3, 0);
    run_seq("t3a", 0, 1, 10, 5, 3);
    cfg_wr = 1'b0;
    run_seq("t3a", 0, 6, 10, 5, 4);
    run_seq("t3b", 0, 11, 6, 3, 0);
    set_cfg(0, 4, 1, 0);
    run_seq("t3w", 0, 1, 6, 3, 5);
    cfg_wr = 1'b0;
    run_seq("t3w", 0, 6, 6, 3, 0);
    run_seq("t3c", 0, 8, 4, 1, 0);

    // drain: drop en two cycles into high
    set_cfg(0, 10, 5, 0);
    run_seq("t5a", 0, 1, 4, 1, 0);
    cfg_wr = 1'b0;
    run_seq("t5a", 0, 3, 4, 1, 1);
    run_seq("t5b", 0, 2, 10, 5, 0);
    en[0] = 1'b0;
    run_seq("t5dr", 0, 8, 10, 5, 2);
    for (int k = 0; k < 3; k++) begin
      chk("t5idle", {29'd0, busy_o[0], wrap_o[0], wave_o[0]}, 32'd0);
      @(negedge clk);
    end
    en[0] = 1'b1;
    @(negedge clk);
    run_seq("t5r", 0, 2, 10, 5, 0);
    en[0] = 1'b0;
    run_seq("t5r", 0, 3, 10, 5, 2);
    en[0] = 1'b1;
    run_seq("t5r", 0, 15, 10, 5, 5);
    en[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5off", {31'd0, busy_o[0]}, 32'd0);

    // ch1: H=0 constant low, H=12 constant high, P=1 behaves as P=2
    set_cfg(1, 10, 0, 0);
    @(negedge clk);
    cfg_wr = 1'b0;
    en[1] = 1'b1;
    @(negedge clk);
    run_seq("t2lo", 1, 10, 10, 0, 0);
    set_cfg(1, 10, 12, 0);
    run_seq("t2lo", 1, 1, 10, 0, 0);
    cfg_wr = 1'b0;
    run_seq("t2lo", 1, 9, 10, 0, 1);
    run_seq("t2hi", 1, 10, 10, 12, 0);
    set_cfg(1, 1, 1, 0);
    run_seq("t2hi", 1, 1, 10, 12, 0);
    cfg_wr = 1'b0;
    run_seq("t2hi", 1, 9, 10, 12, 1);
    run_seq("t2p1", 1, 6, 2, 1, 0);
    en[1] = 1'b0;
    run_seq("t2dr", 1, 2, 2, 1, 0);
    chk("t2idle", {30'd0, busy_o[1], wave_o[1]}, 32'd0);

    // sync_start keeps ch0/ch1 180 degrees apart; idle ch2 stays low
    set_cfg(0, 8, 4, 0);
    @(negedge clk);
    set_cfg(1, 8, 4, 4);
    @(negedge clk);
    cfg_wr = 1'b0;
    en = 3'b011;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      chk_ch("t4pre", 0, k, 8, 4);
      chk_ch("t4pre", 1, (k + 4) % 8, 8, 4);
      if (k == 5) sync_start = 1'b1;
      @(negedge clk);
    end
    sync_start = 1'b0;
    for (int k = 0; k < 18; k++) begin
      chk_ch("t4post", 0, k % 8, 8, 4);
      chk_ch("t4post", 1, (k + 4) % 8, 8, 4);
      chk("t4idle2", {30'd0, busy_o[2], wave_o[2]}, 32'd0);
      @(negedge clk);
    end

    // asynchronous reset while ch0 is high (count 2)
    rst_n = 1'b0;
    #1;
    chk("t6_wave", 32'(wave_o), 32'd0);
    chk("t6_wrap", 32'(wrap_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en[0] = 1'b1;
    @(negedge clk);
    run_seq("t6run", 0, 6, 2, 0, 0);
    chk("t6ch1", {30'd0, busy_o[1], wave_o[1]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
